// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the transmit-issue FSM encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO: circular buffer with wrapping pointers, a separate
// occupancy counter, full/empty flags and a registered overflow pulse.
// A push is dropped when full, even if a pop happens in the same cycle.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   rd_en,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [UART_DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]      r_wr_ptr;
    logic [ADDR_W-1:0]      r_rd_ptr;
    logic [ADDR_W:0]        r_count;
    logic                   r_overflow;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en && !w_full;
    assign w_pop   = rd_en && !w_empty;

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        end
    end

    // Occupancy counter; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle pulse the cycle after a push was dropped for lack of space.
    always_ff @(posedge clk) begin
        if (rst) r_overflow <= 1'b0;
        else     r_overflow <= wr_en && w_full;
    end

    assign rd_data  = r_mem[r_rd_ptr];
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue and issue controller in front of the UART transmitter.
// Handshake: tx_start is a one-cycle registered request carrying tx_data; the
// transmitter acknowledges by raising tx_busy the following cycle and lowers it
// after the stop bit. A new tx_start is only issued from IDLE with tx_busy low,
// and tx_data is held until the next issue.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow,
    output logic                   tx_start,
    output logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_busy,
    output logic [1:0]             dbg_state
);

    tx_state_t              r_state;
    tx_state_t              w_next_state;
    logic                   w_pop;
    logic                   w_empty;
    logic [UART_DATA_W-1:0] w_head;
    logic                   r_tx_start;
    logic [UART_DATA_W-1:0] r_tx_data;

    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (w_pop),
        .rd_data  (w_head),
        .full     (full),
        .empty    (w_empty),
        .count    (count),
        .overflow (overflow)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state: issue, wait for the transmitter to take it, wait for it to finish.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (!w_empty && !tx_busy) w_next_state = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy)              w_next_state = WAIT_DONE;
            WAIT_DONE: if (!tx_busy)             w_next_state = IDLE;
            default:                             w_next_state = IDLE;
        endcase
    end

    // Output decode: the pop happens exactly on the IDLE-to-WAIT_BUSY transition.
    always_comb begin
        w_pop = 1'b0;
        if (r_state == IDLE && !w_empty && !tx_busy) w_pop = 1'b1;
    end

    // Registered transmitter request and held data byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= w_pop;
            if (w_pop) r_tx_data <= w_head;
        end
    end

    assign empty     = w_empty;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural 10-cycles-per-bit transmitter drives
// tx_busy and the serial line, a line decoder recovers frames, and a queue
// model of the FIFO predicts occupancy, flags, overflow and issue order.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_busy;
  logic       full, empty, overflow, tx_start;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .dbg_state (dbg_state)
  );

  // transmitter model: 10 bits (start, 8 data LSB first, stop), 10 cycles each
  logic stall;
  logic m_busy;
  int   m_bit, m_cyc;
  logic line;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_bit <= 0; m_cyc <= 0;
    end else if (!m_busy) begin
      if (tx_start) begin m_busy <= 1'b1; m_bit <= 0; m_cyc <= 0; end
    end else if (m_cyc == 9) begin
      m_cyc <= 0;
      if (m_bit == 9) m_busy <= 1'b0;
      else            m_bit  <= m_bit + 1;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  assign tx_busy = m_busy | stall;
  assign line = !m_busy ? 1'b1 : (m_bit == 0) ? 1'b0 : (m_bit == 9) ? 1'b1 : tx_data[m_bit-1];

  // scoreboard state
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] line_q[$];
  logic [7:0] exp_txd;
  int         epoch = 0;
  int         cyc = 0;
  int         fall_cyc = -1000;
  logic       prev_mbusy = 1'b0;
  logic       prev_start = 1'b0;
  int         n_starts = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: apply one cycle of input, then compare against the queue model
  task automatic step(input logic we, input logic [7:0] d);
    int   pre;
    logic exp_ovf;
    logic [7:0] b;
    wr_en = we; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    cyc++;
    if (prev_mbusy && !m_busy) fall_cyc = cyc;
    prev_mbusy = m_busy;
    pre = exp_q.size();
    exp_ovf = 1'b0;
    if (we) begin
      if (pre == DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(d);
    end
    if (tx_start) begin
      check("start_width", {31'd0, prev_start}, 0);
      check("start_vs_busy", {31'd0, tx_busy}, 0);
      check("start_gap_ok", {31'd0, (cyc - fall_cyc) >= 2}, 1);
      if (pre == 0) begin
        check("spurious_start", 1, 0);
      end else begin
        b = exp_q.pop_front();
        exp_txd = b;
        line_q.push_back(b);
        n_starts++;
      end
    end
    prev_start = tx_start;
    check("count", {27'd0, count}, exp_q.size());
    check("empty", {31'd0, empty}, {31'd0, exp_q.size() == 0});
    check("full", {31'd0, full}, {31'd0, exp_q.size() == DEPTH});
    check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    check("tx_data", {24'd0, tx_data}, {24'd0, exp_txd});
  endtask

  // one-cycle synchronous reset with a push attempt that must be ignored
  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'h5A;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    cyc++;
    exp_q.delete(); line_q.delete();
    epoch++;
    exp_txd = 8'h00;
    prev_start = 1'b0;
    prev_mbusy = m_busy;
    check("rst_tx_start", {31'd0, tx_start}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_count", {27'd0, count}, 0);
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_full", {31'd0, full}, 0);
    check("rst_state", {30'd0, dbg_state}, 0);
    check("rst_busy", {31'd0, tx_busy}, 0);
  endtask

  // run idle cycles until everything queued has been sent and the block is idle
  task automatic drain();
    int budget;
    budget = 20000;
    while (!(exp_q.size() == 0 && !tx_busy && !tx_start && dbg_state == 2'd0) && budget > 0) begin
      step(1'b0, 8'h00);
      budget--;
    end
    check("drain_in_time", {31'd0, budget > 0}, 1);
  endtask

  // serial line decoder: samples mid-bit and compares against issued bytes
  int         mon_ep;
  logic [7:0] mon_b;
  logic       mon_s0, mon_s1;
  always begin
    @(negedge clk);
    if (rst === 1'b0 && line === 1'b0) begin
      mon_ep = epoch;
      repeat (4) @(negedge clk);
      mon_s0 = line;
      for (int i = 0; i < 8; i++) begin
        repeat (10) @(negedge clk);
        mon_b[i] = line;
      end
      repeat (10) @(negedge clk);
      mon_s1 = line;
      if (mon_ep == epoch) begin
        check("line_start_bit", {31'd0, mon_s0}, 0);
        check("line_stop_bit", {31'd0, mon_s1}, 1);
        if (line_q.size() == 0) check("line_unexpected_frame", {24'd0, mon_b}, 32'hFFFF_FFFF);
        else check("line_byte", {24'd0, mon_b}, {24'd0, line_q.pop_front()});
      end
    end
  end

  // watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // directed sequence
  initial begin
    int starts_before;
    int budget;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; stall = 1'b0; exp_txd = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    repeat (3) step(1'b0, 8'h00);

    // single byte: start pulse two edges after the push edge
    step(1'b1, 8'hA5);
    check("single_count1", {27'd0, count}, 1);
    check("single_no_start_yet", {31'd0, tx_start}, 0);
    step(1'b0, 8'h00);
    check("single_start", {31'd0, tx_start}, 1);
    check("single_data", {24'd0, tx_data}, 32'hA5);
    check("single_empty_after", {31'd0, empty}, 1);
    step(1'b0, 8'h00);
    check("single_start_low", {31'd0, tx_start}, 0);
    drain();

    // burst of 16 consecutive pushes
    starts_before = n_starts;
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i));
    drain();
    check("burst_start_count", n_starts - starts_before, 16);

    // overflow with the transmitter stalled
    stall = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)));
    check("ovf_full", {31'd0, full}, 1);
    step(1'b1, 8'hEE);
    check("ovf_pulse", {31'd0, overflow}, 1);
    check("ovf_count", {27'd0, count}, 16);
    step(1'b0, 8'h00);
    check("ovf_pulse_end", {31'd0, overflow}, 0);
    stall = 1'b0;
    drain();

    // push in the exact issue cycle with three queued
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 8'h30 + 8'(i));
    check("sim_count3", {27'd0, count}, 3);
    stall = 1'b0;
    step(1'b1, 8'h77);
    check("sim_issue", {31'd0, tx_start}, 1);
    check("sim_data", {24'd0, tx_data}, 32'h30);
    check("sim_count_kept", {27'd0, count}, 3);
    drain();

    // 40 random bytes at random intervals across the pointer wrap
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 30)) step(1'b0, 8'h00);
      step(1'b1, 8'($urandom));
    end
    drain();

    // reset during the second frame
    starts_before = n_starts;
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i));
    budget = 2000;
    while (n_starts < starts_before + 2 && budget > 0) begin
      step(1'b0, 8'h00);
      budget--;
    end
    check("rst_mid_second_frame", n_starts - starts_before, 2);
    repeat (30) step(1'b0, 8'h00);
    do_reset();
    starts_before = n_starts;
    repeat (300) step(1'b0, 8'h00);
    check("rst_no_more_starts", n_starts - starts_before, 0);
    step(1'b1, 8'h3C);
    drain();
    check("rst_recover_start", n_starts - starts_before, 1);

    repeat (20) step(1'b0, 8'h00);
    check("line_all_frames_seen", line_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte queue and issue controller that sits directly upstream of the UART transmitter. Host logic pushes bytes at any rate up to one per cycle. The block stores them and hands them to the transmitter one frame at a time through its `tx_start`/`tx_data`/`tx_busy` handshake. The block never issues a start while a frame is in flight.

## Interface
- `DEPTH`, default 16: FIFO entries; must be a power of two, ≥ 2.
- `ADDR_W`, default `$clog2(DEPTH)`: pointer width; derived, not overridden.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `wr_en` input 1: push request; sampled every cycle.
- `wr_data` input 8: byte to push.
- `full` output 1: FIFO holds `DEPTH` entries.
- `empty` output 1: FIFO holds 0 entries.
- `count` output `ADDR_W+1`: current occupancy, 0..`DEPTH`.
- `overflow` output 1: one-cycle pulse when a push is dropped.
- `tx_start` output 1: one-cycle request to the transmitter.
- `tx_data` output 8: byte for the transmitter; held stable from `tx_start` until the next issue.
- `tx_busy` input 1: transmitter busy flag; rises the cycle after an accepted `tx_start` and falls after the stop bit.

## Operation
- **Storage**
  - Circular buffer with `ADDR_W`-bit read and write pointers; both wrap modulo `DEPTH`.
  - `count` is a separate `ADDR_W+1`-bit counter: +1 on push, −1 on pop, unchanged when both happen in the same cycle.
  - `full` = (`count` == `DEPTH`); `empty` = (`count` == 0). Both are derived from the registered count.
- **Push**
  - A push is accepted when `wr_en` is high and `full` is low.
  - If `wr_en` is high while `full` is high, the byte is dropped and `overflow` is high in the next cycle. This holds even if a pop happens in the same cycle.
- **Pop** happens only in the IDLE-to-WAIT_BUSY transition.
- **Issue FSM**, 2-bit state:
  - IDLE: if `empty`=0 and `tx_busy`=0 → pop the head, `tx_data`<=head, `tx_start`<=1, go to WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: `tx_start`<=0. If `tx_busy`=1 → WAIT_DONE. Otherwise stay (no timeout).
  - WAIT_DONE: if `tx_busy`=0 → IDLE.
- **Reset values**
  - `tx_start`=0, `tx_data`=0x00, `overflow`=0, `count`=0, `empty`=1, `full`=0.
  - Pointers are 0 and the FSM is in IDLE.
  - Storage contents are don't-care.

## Timing
- `tx_start` is a registered output and is high for exactly one cycle per popped byte.
- Push into an empty FIFO:
  - `wr_en` is sampled at edge N, so `count`=1 after edge N.
  - At edge N+1 the FSM issues, so `tx_start`=1 between edges N+1 and N+2.
  - `count` returns to 0 after edge N+1.
- Back-to-back frames:
  - The next `tx_start` comes no earlier than 2 cycles after `tx_busy` falls: one cycle for WAIT_DONE→IDLE, then the issue edge.
  - There is never a `tx_start` while `tx_busy`=1.
- Push and pop in the same cycle: `count` is unchanged and the pointers advance independently. This is legal at any occupancy 1..`DEPTH`−1.
- Push when `full`=1: the byte is dropped, `count` stays `DEPTH`, and the pointers do not move.
- Pointer wrap: after `DEPTH` pushes the write pointer returns to 0. Ordering is preserved across the wrap.
- `rst` asserted mid-frame:
  - At the next edge, all state returns to its reset values, the queued bytes are discarded, and the FSM goes to IDLE.
  - The transmitter shares `rst`, so `tx_busy` is 0 one cycle later.
- `wr_en` during `rst`: ignored.

## Structure
- **Shared package `uart_pkg`**
  - FSM state typedef: IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2.
  - `UART_DATA_W`=8, shared with the transmitter and receiver.
- **Sub-module `uart_byte_fifo`**: the synchronous FIFO (storage, pointers, count, full/empty, overflow) with push, pop and head-data ports.
  - Reusable on the receive side downstream of the receiver.
  - The top level contains only the issue FSM and the output registers.

## Test plan
Bench instantiates this block driving the UART transmitter with CLK_FREQ=1_000_000 and BAUD_RATE=100_000 (10 cycles per bit); serial line is checked by a bit-level monitor.
- Single byte: push 0xA5 into an empty FIFO → one `tx_start` pulse 2 edges after push with `tx_data`=0xA5; line shows 0, 1,0,1,0,0,1,0,1, 1 (start, LSB first, stop); `empty`=1 afterwards.
- Burst: push 0x01..0x10 on 16 consecutive cycles, `DEPTH`=16 → the sequence is transmitted in order, exactly 16 `tx_start` pulses, `tx_start` never high while `tx_busy`=1, `overflow` never high.
- Overflow: stall `tx_busy` high, fill 16 bytes, push 0xEE → `overflow` is a one-cycle pulse, `count` stays 16, and 0xEE never appears on the line.
- Simultaneous push/pop: with `count`=3 push in the exact issue cycle → `count` stays 3 and the order is preserved.
- Wrap: 40 random bytes pushed at random intervals → output order matches input order across the pointer wrap.
- Reset mid-frame: push 4 bytes, assert `rst` for 1 cycle during the second frame → all outputs at reset values next cycle, `count`=0, no further `tx_start` until a new push.
